cpu_program_loader: RTL and testbench
=====================================

Name: cpu_program_loader

Overview:
- Arbitrates the single port of the program memory between CPU instruction fetch and an external word-serial loader.
- While a load or its read-back verification is in progress, the CPU is held in reset and fetches return NOP.
- When the load finishes, the block reports pass/fail from a checksum comparison and releases the CPU so it restarts at address 0.
- Sits between the CPU core and program memory; the existing tied-off memory data/wren inputs are driven by this block.

Parameters:
- ADDR_W, 9, program memory address width.
- DATA_W, 12, instruction word width.
- DEPTH, 512, number of program words; must be ≤ 2^ADDR_W.
- CSUM_W, 16, checksum accumulator width (modulo 2^CSUM_W).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  ADDR_W  CPU fetch address
- cpu_instr  out  DATA_W  instruction returned to the CPU
- cpu_hold  out  1  reset/hold to the CPU core
- ld_start  in  1  single-cycle request to begin a load
- ld_valid  in  1  loader word valid
- ld_ready  out  1  block accepts a word
- ld_data  in  DATA_W  loader word
- ld_last  in  1  qualifies the final word (sampled with ld_valid)
- ld_done  out  1  single-cycle completion pulse
- ld_err  out  1  checksum mismatch flag, sticky
- mem_address  out  ADDR_W  to program memory
- mem_data  out  DATA_W  to program memory
- mem_wren  out  1  to program memory
- mem_q  in  DATA_W  program memory read data, registered, 1-cycle latency

Behaviour:
- Reset values:
  - state = RUN
  - cpu_hold, ld_ready, ld_done, ld_err, mem_wren all 0
  - wr_ptr, rd_ptr, count, wsum, rsum all 0
  - cpu_instr = 0 (NOP) on the first cycle after reset
- FSM states are RUN, LOAD, VERIFY, DONE. cpu_hold = 1 in LOAD, VERIFY and DONE.
- RUN:
  - mem_address = cpu_addr, mem_wren = 0.
  - cpu_instr = mem_q when the previous cycle was a RUN-state fetch; otherwise 0.
  - ld_start = 1 → LOAD on the next cycle; clear wr_ptr and wsum; clear ld_err.
- LOAD:
  - ld_ready = 1. A word is accepted on a cycle with ld_valid & ld_ready.
  - On accept, in the same cycle (combinational): mem_address = wr_ptr, mem_data = ld_data, mem_wren = 1.
  - Registered on accept: wr_ptr += 1; wsum = (wsum + zero-extended ld_data) mod 2^CSUM_W.
  - Leave for VERIFY when the accepted word has ld_last = 1, or when the accepted word is at wr_ptr == DEPTH-1 (memory full, ld_last ignored). count = wr_ptr + 1 at transition.
  - No wrap-around: words past DEPTH are never accepted because ld_ready drops.
  - When not accepting: mem_address = wr_ptr, mem_wren = 0.
  - cpu_instr = 0.
- VERIFY:
  - ld_ready = 0, mem_wren = 0.
  - mem_address = rd_ptr, with rd_ptr running 0 .. count-1, one read per cycle.
  - mem_q is accumulated into rsum one cycle after each read.
  - After the accumulate for address count-1 → DONE.
  - Total VERIFY duration is count + 1 cycles. rsum and rd_ptr are cleared on entry.
- DONE:
  - Lasts one cycle: ld_done = 1; ld_err <= (rsum != wsum); next state RUN.
  - cpu_hold drops on the first RUN cycle; the CPU restarts its fetch from address 0.
- ld_start is ignored outside RUN.
- ld_start and a simultaneous fetch in RUN: the fetch completes normally on that cycle; cpu_instr = 0 from the next cycle.
- ld_valid in RUN, VERIFY or DONE is ignored; ld_ready = 0.
- rst mid-load or mid-verify: synchronous return to RUN with reset values. Memory contents are partial and not restored. No ld_done pulse.
- ld_err holds until the next ld_start or rst.

Decomposition:
- Shared package holds:
  - state encoding (RUN = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, DONE = 2'd3)
  - NOP constant 12'h000
- One sub-module is natural: cpu_loader_checksum (clear, add-enable, data in, CSUM_W sum out), instanced twice, for wsum and rsum.

Test Plan:
- Run fetch: load memory model addr 5 = 12'hA5C; drive cpu_addr = 5 → cpu_instr = 12'hA5C one cycle later; cpu_hold = 0; mem_wren never high.
- Basic load:
  - Stimulus: ld_start, then words 12'h001, 12'h0FF, 12'hC07, 12'h800 (last), with ld_valid gaps.
  - Required: exactly 4 mem_wren pulses at addr 0–3; VERIFY reads 0–3; ld_done pulses 6 cycles after the last accept (VERIFY 5 + DONE 1); ld_err = 0.
  - Required: cpu_hold high from the cycle after ld_start through DONE; cpu_instr = 0 throughout.
- Corruption: memory model flips bit 0 of addr 2 after its write → ld_done with ld_err = 1; ld_err stays 1 until the next ld_start.
- Full memory: stream DEPTH words with ld_last never set → ld_ready drops after word 511; count = 512; ld_err = 0; a 513th ld_valid is not accepted.
- ld_start during LOAD and during VERIFY → no restart; wr_ptr and rd_ptr unaffected; single ld_done.
- rst asserted after 2 words accepted → next cycle: RUN, cpu_hold = 0, ld_ready = 0, no ld_done; a subsequent full load passes.

Source files
------------

// File: rtl/cpu_program_loader_pkg.sv
// Shared types and constants for the CPU program loader.
package cpu_program_loader_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [11:0] NOP = 12'h000;

endpackage

// File: rtl/cpu_program_loader_checksum.sv
// Modulo-2^CSUM_W running sum of zero-extended data words.
module cpu_loader_checksum #(
  parameter int DATA_W = 12,
  parameter int CSUM_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CSUM_W-1:0] sum_o
);

  logic [CSUM_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + CSUM_W'(data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/cpu_program_loader.sv
// Shares the program memory port between CPU fetch and a word-serial loader,
// holding the CPU while a load and its checksum read-back are in progress.
module cpu_program_loader
  import cpu_program_loader_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 512,
  parameter int CSUM_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_hold,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output state_e            dbg_state
);

  // Pointers carry one extra bit so a full memory gives count == DEPTH.
  localparam int CNT_W = ADDR_W + 1;

  // Loader handshake: a word transfers on a cycle where ld_valid and
  // ld_ready are both high; ld_ready is high only in LOAD while space remains.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_vld_q, rd_vld_d;
  logic             fetch_q;
  logic             ld_err_q, ld_err_d;
  logic             wsum_clr, wsum_add, rsum_clr, rsum_add;
  logic [CSUM_W-1:0] wsum, rsum;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_vld_d    = 1'b0;
    ld_err_d    = ld_err_q;
    wsum_clr    = 1'b0;
    wsum_add    = 1'b0;
    rsum_clr    = 1'b0;
    rsum_add    = 1'b0;
    cpu_hold    = 1'b1;
    cpu_instr   = DATA_W'(NOP);
    ld_ready    = 1'b0;
    ld_done     = 1'b0;
    mem_address = wr_ptr_q[ADDR_W-1:0];
    mem_data    = '0;
    mem_wren    = 1'b0;
    case (state_q)
      ST_RUN: begin
        cpu_hold    = 1'b0;
        mem_address = cpu_addr;
        if (fetch_q) cpu_instr = mem_q;
        if (ld_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          wsum_clr = 1'b1;
          ld_err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        ld_ready = (wr_ptr_q < CNT_W'(DEPTH));
        if (ld_valid && ld_ready) begin
          mem_data = ld_data;
          mem_wren = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          wsum_add = 1'b1;
          if (ld_last || (wr_ptr_q == CNT_W'(DEPTH - 1))) begin
            state_d  = ST_VERIFY;
            count_d  = wr_ptr_q + 1'b1;
            rd_ptr_d = '0;
            rsum_clr = 1'b1;
          end
        end
      end
      ST_VERIFY: begin
        mem_address = rd_ptr_q[ADDR_W-1:0];
        if (rd_ptr_q < count_q) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          rd_vld_d = 1'b1;
        end
        // mem_q holds the word read on the previous cycle.
        if (rd_vld_q) begin
          rsum_add = 1'b1;
          if (rd_ptr_q == count_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ld_done  = 1'b1;
        ld_err_d = (rsum != wsum);
        state_d  = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_vld_q <= 1'b0;
      fetch_q  <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_vld_q <= rd_vld_d;
      fetch_q  <= (state_q == ST_RUN);
      ld_err_q <= ld_err_d;
    end
  end

  cpu_loader_checksum #(.DATA_W(DATA_W), .CSUM_W(CSUM_W)) u_wsum (
    .clk     (clk),
    .rst     (rst),
    .clear_i (wsum_clr),
    .add_i   (wsum_add),
    .data_i  (ld_data),
    .sum_o   (wsum)
  );

  cpu_loader_checksum #(.DATA_W(DATA_W), .CSUM_W(CSUM_W)) u_rsum (
    .clk     (clk),
    .rst     (rst),
    .clear_i (rsum_clr),
    .add_i   (rsum_add),
    .data_i  (mem_q),
    .sum_o   (rsum)
  );

  assign ld_err    = ld_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Randomized bench for cpu_program_loader with a memory model and reference sums.
module tb_cpu_program_loader;
  import cpu_program_loader_pkg::*;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  cpu_addr;
  logic [11:0] cpu_instr;
  logic        cpu_hold;
  logic        ld_start, ld_valid, ld_ready, ld_last, ld_done, ld_err;
  logic [11:0] ld_data;
  logic [8:0]  mem_address;
  logic [11:0] mem_data, mem_q;
  logic        mem_wren;
  state_e      dbg_state;

  logic [11:0] mem_model [DEPTH];
  logic [11:0] ref_mem [DEPTH];
  logic        corrupt_en, pre_en;
  logic [8:0]  pre_addr;
  logic [11:0] pre_data;
  logic [11:0] stim_q[$];
  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  cpu_program_loader dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
    .cpu_hold(cpu_hold), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_done(ld_done), .ld_err(ld_err), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Program memory: registered read, read-before-write, optional bit-0 fault at address 2.
  always @(posedge clk) begin
    mem_q <= mem_model[mem_address];
    if (mem_wren)
      mem_model[mem_address] <= (corrupt_en && mem_address == 9'd2) ? (mem_data ^ 12'h001) : mem_data;
    else if (pre_en)
      mem_model[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_test(input int n);
    logic [8:0]  a;
    logic [11:0] d;
    for (int i = 0; i < n; i++) begin
      a = (i == 0) ? 9'd5 : 9'($urandom_range(0, DEPTH - 1));
      d = (i == 0) ? 12'hA5C : 12'($urandom);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
      @(negedge clk);
      pre_en = 1'b0; cpu_addr = a;
      #1;
      check("run_hold", cpu_hold, 0);
      check("run_wren", mem_wren, 0);
      @(negedge clk);
      #1;
      check("fetch", cpu_instr, d);
      check("run_wren", mem_wren, 0);
    end
  endtask

  // Drives one load from stim_q and checks writes, read-back order, timing and result.
  task automatic run_load(input bit use_last, input bit poke, input bit corrupt);
    int          n_offer, n_exp, acc, last_acc, k, budget;
    bit          finished;
    logic [15:0] wsum_m, rsum_m;
    logic [11:0] w;
    bit          exp_err;
    n_offer = stim_q.size();
    n_exp   = use_last ? n_offer : DEPTH;
    budget  = 8 * n_exp + 64;
    corrupt_en = corrupt;
    exp_q = stim_q;
    acc = 0; last_acc = -1; finished = 1'b0;
    @(negedge clk);
    ld_start = 1'b1; ld_valid = 1'b0;
    #1;
    check("start_hold", cpu_hold, 0);
    for (int c = 0; c < budget && !finished; c++) begin
      @(negedge clk);
      ld_start = poke && ($urandom_range(0, 5) == 0);
      cpu_addr = 9'($urandom);
      ld_valid = ($urandom_range(0, 3) != 0);
      if (acc < n_offer) begin
        ld_data = stim_q[acc];
        ld_last = use_last && (acc == n_offer - 1);
      end else begin
        ld_data = 12'($urandom);
        ld_last = 1'($urandom);
      end
      #1;
      check("hold", cpu_hold, 1);
      check("instr_nop", cpu_instr, 0);
      check("err_cleared", ld_err, 0);
      if (acc < n_exp) begin
        check("ready", ld_ready, 1);
        check("wren", mem_wren, ld_valid);
        check("done_early", ld_done, 0);
        if (ld_valid) begin
          w = exp_q.pop_front();
          check("wr_addr", mem_address, acc);
          check("wr_data", mem_data, w);
          ref_mem[acc] = (corrupt && acc == 2) ? (w ^ 12'h001) : w;
          acc++;
          if (acc == n_exp) last_acc = c;
        end
      end else begin
        k = c - last_acc - 1;
        check("ready_off", ld_ready, 0);
        check("wren_off", mem_wren, 0);
        if (k < n_exp) check("rd_addr", mem_address, k);
        check("done", ld_done, (k == n_exp + 1) ? 1 : 0);
        if (k >= n_exp + 1) finished = 1'b1;
      end
    end
    if (!finished) check("done_timeout", 0, 1);
    wsum_m = '0; rsum_m = '0;
    for (int i = 0; i < n_exp; i++) begin
      wsum_m = wsum_m + 16'(stim_q[i]);
      rsum_m = rsum_m + 16'(ref_mem[i]);
    end
    exp_err = (wsum_m != rsum_m);
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; cpu_addr = 9'd0;
    #1;
    check("post_hold", cpu_hold, 0);
    check("post_state", dbg_state, ST_RUN);
    check("post_done", ld_done, 0);
    check("post_instr", cpu_instr, 0);
    check("post_err", ld_err, exp_err);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) check("restart_fetch", cpu_instr, ref_mem[0]);
      check("err_sticky", ld_err, exp_err);
      check("run_wren", mem_wren, 0);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; ld_start = 1'b0; ld_valid = 1'b0;
    ld_data = '0; ld_last = 1'b0; corrupt_en = 1'b0; pre_en = 1'b0;
    pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", dbg_state, ST_RUN);
    check("rst_hold", cpu_hold, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_done", ld_done, 0);
    check("rst_err", ld_err, 0);
    check("rst_wren", mem_wren, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_instr", cpu_instr, 0);

    fetch_test(12);

    stim_q = '{12'h001, 12'h0FF, 12'hC07, 12'h800};
    run_load(1'b1, 1'b0, 1'b0);

    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(12'($urandom));
    run_load(1'b1, 1'b0, 1'b1);

    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back(12'($urandom));
    run_load(1'b1, 1'b1, 1'b0);

    stim_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) stim_q.push_back(12'($urandom));
    run_load(1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      stim_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) stim_q.push_back(12'($urandom));
      run_load(1'b1, 1'($urandom), 1'b0);
    end

    // Reset after two accepted words.
    @(negedge clk);
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 12'($urandom); ld_last = 1'b0;
    #1;
    check("mid_ready", ld_ready, 1);
    @(negedge clk);
    ld_data = 12'($urandom);
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, ST_RUN);
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_ready", ld_ready, 0);
    check("mid_rst_done", ld_done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("mid_rst_nodone", ld_done, 0);
      check("mid_rst_hold", cpu_hold, 0);
    end

    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) stim_q.push_back(12'($urandom));
    run_load(1'b1, 1'b0, 1'b0);

    fetch_test(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
